// File: rtl/nibble_serial_sub_ctrl.sv
// Wide subtractor D = A - B built from one 4-bit borrow-chained slice,
// stepping one nibble per clock from the least significant nibble upward.
module nibble_serial_sub_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   D,
   output logic                   borrow_out
);

   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [W-1:0]    a_reg;
   logic [W-1:0]    b_reg;
   logic [IW-1:0]   idx;
   logic            borrow;
   logic [3:0]      a_nib;
   logic [3:0]      b_nib;
   logic [4:0]      slice;
   logic            last;

   // Shared slice: bit 4 of the 5-bit difference is the borrow out.
   always_comb begin
      a_nib = a_reg[{idx, 2'b00} +: 4];
      b_nib = b_reg[{idx, 2'b00} +: 4];
      slice = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, borrow};
      last  = (idx == LAST_IDX);
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (last)  state_next = FIN;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         idx        <= '0;
         borrow     <= 1'b0;
         D          <= '0;
         borrow_out <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg      <= A;
                  b_reg      <= B;
                  idx        <= '0;
                  borrow     <= 1'b0;
                  D          <= '0;
                  borrow_out <= 1'b0;
                  busy       <= 1'b1;
               end
            end
            RUN: begin
               D[{idx, 2'b00} +: 4] <= slice[3:0];
               borrow               <= slice[4];
               // idx parks on the last nibble; the next accept clears it.
               if (last) begin
                  borrow_out <= slice[4];
                  busy       <= 1'b0;
                  done       <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            FIN: begin
               done <= 1'b0;
            end
            default: begin
               done <= 1'b0;
               busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Scoreboard bench for nibble_serial_sub_ctrl: stimulus pushes the reference
// {borrow, difference}, a monitor pops it whenever done pulses.
module tb_nibble_serial_sub_ctrl;

   localparam int N = 4;
   localparam int W = 4 * N;

   logic           clk;
   logic           rst;
   logic           start;
   logic [W-1:0]   A;
   logic [W-1:0]   B;
   logic           busy;
   logic           done;
   logic [W-1:0]   D;
   logic           borrow_out;

   logic [W:0]     expq[$];
   int             total;
   int             bad;

   nibble_serial_sub_ctrl #(.NIBBLES(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .A          (A),
      .B          (B),
      .busy       (busy),
      .done       (done),
      .D          (D),
      .borrow_out (borrow_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding operation.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst && done) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_done: got D=%0h bo=%0b expected no pulse", D, borrow_out);
            end else begin
               logic [W:0] e;
               e = expq.pop_front();
               checkOutput("result", 64'({borrow_out, D}), 64'(e));
            end
         end
      end
   end

   // One operation from an idle DUT; disturb pokes start and operands mid-run.
   task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
      logic [W:0]   exp;
      logic [W:0]   one;
      logic [W-1:0] mask;
      A     = a;
      B     = b;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      exp   = {1'b0, a} - {1'b0, b};
      expq.push_back(exp);
      one = 1;
      for (int k = 1; k <= N; k++) begin
         mask = W'((one << (4 * (k - 1))) - 1);
         checkOutput("busy_run", 64'(busy), 64'd1);
         checkOutput("done_run", 64'(done), 64'd0);
         checkOutput("partial_d", 64'(D), 64'(exp[W-1:0] & mask));
         if (disturb && k == 2) begin
            start = 1'b1;
            A     = '0;
            B     = '0;
         end
         if (disturb && k == 3) begin
            start = 1'b0;
            A     = W'($urandom());
            B     = W'($urandom());
         end
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      checkOutput("busy_fin", 64'(busy), 64'd0);
      checkOutput("done_fin", 64'(done), 64'd1);
      @(posedge clk);
      #1;
      checkOutput("done_clear", 64'(done), 64'd0);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      int           r;
      int           waitc;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      start = 1'b0;
      A     = '0;
      B     = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_d", 64'(D), 64'd0);
      checkOutput("rst_bo", 64'(borrow_out), 64'd0);
      rst = 1'b0;

      applyStimulus(16'h0002, 16'h0000, 1'b0);
      applyStimulus(16'h0000, 16'h000F, 1'b0);
      applyStimulus(16'h0001, 16'h000E, 1'b0);
      applyStimulus(16'h0100, 16'h0001, 1'b0);
      applyStimulus(16'h1234, 16'h1234, 1'b0);
      applyStimulus(16'hFFFF, 16'h0000, 1'b0);
      applyStimulus(16'h8000, 16'h0001, 1'b1);

      // Reset on the second run cycle abandons the operation silently.
      A     = 16'h1234;
      B     = 16'h4321;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midrst_busy", 64'(busy), 64'd0);
      checkOutput("midrst_d", 64'(D), 64'd0);
      checkOutput("midrst_done", 64'(done), 64'd0);
      checkOutput("midrst_bo", 64'(borrow_out), 64'd0);
      rst = 1'b0;
      repeat (N + 3) @(posedge clk);
      #1;
      applyStimulus(16'h0005, 16'h0007, 1'b0);

      // Held start: one accept every N+2 cycles.
      A     = 16'h0010;
      B     = 16'h0001;
      start = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i % (N + 2) == 0) expq.push_back({1'b0, A} - {1'b0, B});
         @(posedge clk);
         #1;
      end
      start = 1'b0;
      waitc = 0;
      while (expq.size() != 0 && waitc < 100) begin
         @(posedge clk);
         waitc++;
      end
      #1;
      checkOutput("held_drain", 64'(expq.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;

      for (int n = 0; n < 1000; n++) begin
         a = W'($urandom());
         b = W'($urandom());
         r = $urandom_range(0, 7);
         if (r == 0) b = a;
         if (r == 1) a = '0;
         if (r == 2) b = '1;
         applyStimulus(a, b, 1'b0);
      end

      waitc = 0;
      while (expq.size() != 0 && waitc < 100) begin
         @(posedge clk);
         waitc++;
      end
      #1;
      checkOutput("queue_drain", 64'(expq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
